memory_responder: RTL and testbench

Word-organised main memory with a request/ready handshake. It acts as the responder for the datapath's memory port: it takes the MAR address and MDR write data, performs reads and writes after a programmable number of wait states, and returns read data for MDR capture on the M bus. The control unit issues RD/WR and holds its MMD/MDM microstep until READY pulses.

---
 rtl/memory_responder.sv | 137 +++++++++++++
 tb/tb_memory_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Word-organised main memory that answers RD/WR requests after WAIT_CYCLES wait states
// and returns a one-cycle READY pulse, with ERR qualifying bad requests.
module memory_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [15:0] MAR_in,
  input  logic [15:0] M_bus_wr,
  input  logic        RD,
  input  logic        WR,
  output logic [15:0] M_bus_rd,
  output logic        READY,
  output logic        BUSY,
  output logic        ERR
);

  localparam int unsigned Words = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  word_q, word_d;
  logic [15:0]           data_q, data_d;
  logic                  is_rd_q, is_rd_d;
  logic                  err_q, err_d;
  logic [15:0]           rd_data_q, rd_data_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  err_out_q, err_out_d;
  logic                  mem_we;

  logic [15:0] mem [Words];

  logic        req;
  logic        odd_addr;
  logic        out_of_range;
  logic        dual_req;
  logic [15:0] upper_bits;

  assign req          = RD | WR;
  assign odd_addr     = MAR_in[0];
  // Anything above the top word address means the byte address is past the array.
  assign upper_bits   = MAR_in >> (ADDR_BITS + 1);
  assign out_of_range = |upper_bits;
  assign dual_req     = RD & WR;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    data_d    = data_q;
    is_rd_d   = is_rd_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    mem_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          word_d  = MAR_in[ADDR_BITS:1];
          data_d  = M_bus_wr;
          // A simultaneous RD+WR is treated as an (erroring) read.
          is_rd_d = RD;
          err_d   = odd_addr | out_of_range | dual_req;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StAck;
          if (err_q) begin
            if (is_rd_q) rd_data_d = 16'h0000;
          end else if (is_rd_q) begin
            rd_data_d = mem[word_q];
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ready_d   = (state_d == StAck);
    busy_d    = (state_d != StIdle);
    err_out_d = (state_d == StAck) & err_d;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      word_q    <= '0;
      data_q    <= 16'h0000;
      is_rd_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= 16'h0000;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      data_q    <= data_d;
      is_rd_q   <= is_rd_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      err_out_q <= err_out_d;
    end
  end

  // The array has no reset: contents survive CLR.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[word_q] <= data_q;
    end
  end

  assign M_bus_rd = rd_data_q;
  assign READY    = ready_q;
  assign BUSY     = busy_q;
  assign ERR      = err_out_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed and random transactions on a WAIT_CYCLES=2 instance
// plus a held-request run on a WAIT_CYCLES=0 instance, checked against a countdown model.
module tb_memory_responder;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] mar, wdata;
  logic        rdv [2];
  logic        wrv [2];
  logic [15:0] mrd [2];
  logic        rdy [2];
  logic        bsy [2];
  logic        erro [2];

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  memory_responder #(.ADDR_BITS(10), .WAIT_CYCLES(W0)) u_dut (
    .CLK(clk), .CLR(clr), .MAR_in(mar), .M_bus_wr(wdata), .RD(rdv[0]), .WR(wrv[0]),
    .M_bus_rd(mrd[0]), .READY(rdy[0]), .BUSY(bsy[0]), .ERR(erro[0])
  );

  memory_responder #(.ADDR_BITS(10), .WAIT_CYCLES(W1)) u_dut0 (
    .CLK(clk), .CLR(clr), .MAR_in(mar), .M_bus_wr(wdata), .RD(rdv[1]), .WR(wrv[1]),
    .M_bus_rd(mrd[1]), .READY(rdy[1]), .BUSY(bsy[1]), .ERR(erro[1])
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: rem counts cycles left in the transaction; READY is its last cycle.
  int          rem  [2];
  logic [15:0] mm   [2][1024];
  bit          mk   [2][1024];
  logic [9:0]  lw   [2];
  logic [15:0] ld   [2];
  bit          lrd  [2];
  bit          lerr [2];
  logic [15:0] erd  [2];
  bit          erk  [2];

  function automatic int waits(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  function automatic void model_step(input int i);
    if (clr) begin
      rem[i] = 0;
      erd[i] = 16'h0000;
      erk[i] = 1'b1;
    end else if (rem[i] == 0) begin
      if (rdv[i] || wrv[i]) begin
        lw[i]   = mar[10:1];
        ld[i]   = wdata;
        lrd[i]  = rdv[i];
        lerr[i] = mar[0] || (mar >= 16'h0800) || (rdv[i] && wrv[i]);
        rem[i]  = waits(i) + 2;
      end
    end else begin
      rem[i]--;
      if (rem[i] == 1) begin
        if (lerr[i]) begin
          if (lrd[i]) begin
            erd[i] = 16'h0000;
            erk[i] = 1'b1;
          end
        end else if (lrd[i]) begin
          erd[i] = mm[i][lw[i]];
          erk[i] = mk[i][lw[i]];
        end else begin
          mm[i][lw[i]] = ld[i];
          mk[i][lw[i]] = 1'b1;
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.READY", i), 16'(rdy[i]), 16'(rem[i] == 1));
      chk($sformatf("u%0d.BUSY", i), 16'(bsy[i]), 16'(rem[i] > 0));
      chk($sformatf("u%0d.ERR", i), 16'(erro[i]), 16'((rem[i] == 1) && lerr[i]));
      if (erk[i]) chk($sformatf("u%0d.M_bus_rd", i), mrd[i], erd[i]);
    end
  end

  task automatic txn(input int i, input bit r, input bit w, input logic [15:0] a,
                     input logic [15:0] d, output int lat, output logic [15:0] q,
                     output logic e);
    @(negedge clk);
    rdv[i] = r; wrv[i] = w; mar = a; wdata = d;
    @(negedge clk);
    rdv[i] = 1'b0; wrv[i] = 1'b0;
    mar = 16'($urandom); wdata = 16'($urandom);
    lat = 0;
    while (!rdy[i] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q = mrd[i];
    e = erro[i];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [15:0] q;
    logic        e;
    int          pulses, lows, last;
    int          kind, word;
    logic [15:0] a;

    clr = 1'b1; mar = '0; wdata = '0;
    rdv[0] = 0; rdv[1] = 0; wrv[0] = 0; wrv[1] = 0;
    repeat (2) @(negedge clk);
    chk("rst READY", 16'(rdy[0]), 16'h0);
    chk("rst BUSY", 16'(bsy[0]), 16'h0);
    chk("rst ERR", 16'(erro[0]), 16'h0);
    chk("rst M_bus_rd", mrd[0], 16'h0000);
    clr = 1'b0;

    for (int j = 0; j <= 16; j++) begin
      txn(0, 0, 1, 16'(j * 2), 16'(16'hA000 + j), lat, q, e);
    end

    txn(0, 0, 1, 16'h0010, 16'h1234, lat, q, e);
    chk("wr latency", 16'(lat), 16'd3);
    chk("wr err", 16'(e), 16'h0);
    txn(0, 1, 0, 16'h0010, 16'h0000, lat, q, e);
    chk("rd latency", 16'(lat), 16'd3);
    chk("rd data", q, 16'h1234);
    chk("rd err", 16'(e), 16'h0);

    // Abandon a write of 0xBEEF to 0x0020 with CLR during WAIT.
    @(negedge clk);
    wrv[0] = 1'b1; mar = 16'h0020; wdata = 16'hBEEF;
    @(negedge clk);
    wrv[0] = 1'b0;
    clr = 1'b1;
    #1;
    chk("clr READY", 16'(rdy[0]), 16'h0);
    chk("clr BUSY", 16'(bsy[0]), 16'h0);
    chk("clr ERR", 16'(erro[0]), 16'h0);
    chk("clr M_bus_rd", mrd[0], 16'h0000);
    @(negedge clk);
    clr = 1'b0;
    txn(0, 1, 0, 16'h0020, 16'h0000, lat, q, e);
    chk("post-clr data", q, 16'hA010);

    txn(0, 1, 0, 16'h0011, 16'h0000, lat, q, e);
    chk("odd err", 16'(e), 16'h1);
    chk("odd data", q, 16'h0000);

    txn(0, 0, 1, 16'h0800, 16'hFFFF, lat, q, e);
    chk("oor err", 16'(e), 16'h1);
    txn(0, 1, 0, 16'h0000, 16'h0000, lat, q, e);
    chk("oor alias", q, 16'hA000);

    txn(0, 1, 1, 16'h0004, 16'h5555, lat, q, e);
    chk("rdwr err", 16'(e), 16'h1);
    txn(0, 1, 0, 16'h0004, 16'h0000, lat, q, e);
    chk("rdwr unchanged", q, 16'hA002);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      word = $urandom_range(0, 16);
      a = 16'(word * 2);
      case (kind)
        0:       txn(0, 1, 0, a | 16'h0001, 16'($urandom), lat, q, e);
        1:       txn(0, $urandom_range(0, 1) == 1, 1, 16'h0800 | 16'($urandom & 16'h07FE),
                     16'($urandom), lat, q, e);
        2:       txn(0, 1, 1, a, 16'($urandom), lat, q, e);
        3, 4, 5: txn(0, 1, 0, a, 16'($urandom), lat, q, e);
        default: txn(0, 0, 1, a, 16'($urandom), lat, q, e);
      endcase
      chk("rand latency", 16'(lat), 16'(W0 + 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    txn(1, 0, 1, 16'h0002, 16'h0042, lat, q, e);
    chk("u1 wr latency", 16'(lat), 16'd1);
    txn(1, 0, 1, 16'h0004, 16'h0044, lat, q, e);

    // Held RD on the zero-wait instance.
    @(negedge clk);
    mar = 16'h0002; rdv[1] = 1'b1;
    pulses = 0; lows = 0; last = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rdy[1]) begin
        if (last >= 0) chk("held spacing", 16'(c - last), 16'd3);
        else chk("held first data", mrd[1], 16'h0042);
        pulses++;
        last = c;
      end
      if (!bsy[1]) lows++;
      if (c == 5) mar = 16'h0004;
    end
    rdv[1] = 1'b0;
    chk("held pulses", 16'(pulses), 16'd4);
    chk("held busy lows", 16'(lows), 16'd4);
    chk("held last data", mrd[1], 16'h0044);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
